load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-access stage downstream of the integer datapath.
- Inputs: the effective address (datapath ALU output), the store data (datapath D_OUT), and control from the control unit.
- Drives a word-wide data memory through a req/ack handshake with variable wait states.
- Returns lane-aligned, optionally sign-extended load data to the datapath's external DY input.
- Flags misaligned accesses and memory timeouts.

Parameters:
- TIMEOUT, 16: maximum number of REQ cycles without mem_ack before the access aborts. Legal range is 2..255.
- CNT_W, 8: width of the wait-state counter.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request from the control unit. Sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal.
- sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  in  32  byte address.
- wdata  in  32  store data, right-justified.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle completion pulse, for both success and error.
- rdata  out  32  load result, driven to DY.
- misalign  out  1  valid with done: alignment or size error.
- timeout  out  1  valid with done: no ack within TIMEOUT cycles.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write strobe.
- mem_addr  out  32  word address, {addr[31:2], 2'b00}.
- mem_be  out  4  byte enables. Little-endian: lane k = bits [8k+7:8k].
- mem_wdata  out  32  replicated store data.
- mem_rdata  in  32  memory read word.
- mem_ack  in  1  memory completion. Sampled only in REQ.

Behaviour:
- One clock domain (CLK); synchronous active-high RESET.
- Reset behaviour:
  - State goes to IDLE and the counter clears.
  - All outputs are 0, including rdata = 0x00000000.
  - Reset asserted mid-access aborts it: mem_req is low from the next cycle and no done pulse is produced.
- States: IDLE, REQ, DONE, ERR. Outputs are Moore-decoded from the state and registered request fields.
- IDLE:
  - On start = 1, latch we, size, sign_ext, addr and wdata.
  - Misaligned means size = 3, size = 1 with addr[0] = 1, or size = 2 with addr[1:0] != 0.
  - Misaligned: go to ERR with misalign set. No memory cycle is issued.
  - Otherwise: go to REQ with counter = 0.
  - start while busy is ignored.
- REQ:
  - mem_req = 1. mem_we, mem_addr, mem_be and mem_wdata are held stable from the latched fields.
  - If mem_ack = 1: go to DONE. For a load, rdata captures the extracted lane on this edge.
  - Else if counter == TIMEOUT-1: go to ERR with timeout set.
  - Else: counter increments.
- DONE: done = 1 for one cycle, then IDLE.
- ERR: done = 1 and the relevant flag = 1 for one cycle, then IDLE. Both flags clear in IDLE.
- Latency with a zero-wait ack: start at edge 0, REQ in cycle 1, done in cycle 2. Each memory wait state adds one cycle.
- Byte enables:
  - byte: 4'b0001 << addr[1:0].
  - half: 4'b0011 << addr[1:0].
  - word: 4'b1111.
- Store data:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata.
- Load data:
  - Select the lane from mem_rdata using addr[1:0].
  - Extend to 32 bits by sign_ext (sign bit is bit 7 or bit 15). Word loads ignore sign_ext.
- rdata changes only on a successful load. It holds across stores and errors.
- mem_ack outside REQ is ignored.

Decomposition:
- Shared package: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state encodings, and the TIMEOUT default.
- One combinational sub-module, ls_lane_align. It contains byte-enable generation, store replication and load extract/extend.
- The FSM, counter and latches live in the top module.

Test Plan:
1. Word store: addr = 0x00000100, wdata = 0xDEADBEEF, mem_ack two cycles after mem_req rises → mem_be = 1111, mem_wdata = 0xDEADBEEF, mem_addr = 0x100, done in cycle 4, rdata unchanged.
2. Signed byte load: addr = 0x00000103, mem_rdata = 0x80FF1234, ack immediate → mem_be = 1000, rdata = 0xFFFFFF80, done in cycle 2.
3. Unsigned half load: addr = 0x102, mem_rdata = 0x80FF1234 → mem_be = 1100, rdata = 0x000080FF. The same access with sign_ext = 1 → 0xFFFF80FF.
4. Misaligned access:
   - Word at 0x102 → done and misalign in cycle 1, mem_req never asserted.
   - size = 3 → same response.
5. Timeout: load with no ack → mem_req high for exactly TIMEOUT (16) cycles, then done and timeout. rdata is unchanged.
6. Control edge cases:
   - RESET asserted in the second REQ cycle → next cycle IDLE, mem_req = 0, no done, rdata = 0.
   - start pulsed while busy → ignored, no second access.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: access-size encodings, FSM
// state encoding, the default timeout and the alignment rule.
package load_store_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int unsigned TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {StIdle, StReq, StDone, StErr} ls_state_e;

  // Size 3 is never legal; halfwords need an even address, words a 4-byte boundary.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return addr_lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Lane alignment for the load/store unit (purely combinational).
//   size_i, addr_lo_i : access size and low address bits of the latched request
//   sign_ext_i        : sign-extend narrow loads
//   wdata_i           : right-justified store data
//   mem_rdata_i       : word read from memory
//   be_o              : byte enables, lane k = bits [8k+7:8k]
//   wdata_rep_o       : store data replicated across all lanes
//   rdata_o           : selected load lane, extended to 32 bits
module ls_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        sign_ext_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] mem_rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_rep_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halfword select only needs addr[1]; addr[0] is zero for any legal halfword.
  assign byte_sel = mem_rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign half_sel = mem_rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

  always_comb begin
    be_o        = 4'b0000;
    wdata_rep_o = wdata_i;
    rdata_o     = mem_rdata_i;
    case (size_i)
      SZ_BYTE: begin
        be_o        = 4'b0001 << addr_lo_i;
        wdata_rep_o = {4{wdata_i[7:0]}};
        rdata_o     = {{24{sign_ext_i & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        be_o        = 4'b0011 << addr_lo_i;
        wdata_rep_o = {2{wdata_i[15:0]}};
        rdata_o     = {{16{sign_ext_i & half_sel[15]}}, half_sel};
      end
      SZ_WORD: begin
        be_o = 4'b1111;
      end
      default: begin
        be_o = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: memory-access stage between the integer datapath and a
// word-wide data memory with a req/ack handshake.
//   CLK, RESET            : clock, synchronous active-high reset
//   start, we, size,
//   sign_ext, addr, wdata : request from the control unit (sampled in IDLE)
//   busy, done            : status; done pulses once per access
//   misalign, timeout     : error flags, valid with done
//   rdata                 : last successful load result
//   mem_*                 : memory port, driven only while a request is active
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        start,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        timeout,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  ls_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [1:0]       size_q, size_d;
  logic             sext_q, sext_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             misalign_q, misalign_d;
  logic             timeout_q, timeout_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;

  ls_lane_align u_lane_align (
    .size_i      (size_q),
    .addr_lo_i   (addr_q[1:0]),
    .sign_ext_i  (sext_q),
    .wdata_i     (wdata_q),
    .mem_rdata_i (mem_rdata),
    .be_o        (lane_be),
    .wdata_rep_o (lane_wdata),
    .rdata_o     (lane_rdata)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    size_d     = size_q;
    sext_d     = sext_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    misalign_d = misalign_q;
    timeout_d  = timeout_q;
    rdata_d    = rdata_q;
    unique case (state_q)
      StIdle: begin
        misalign_d = 1'b0;
        timeout_d  = 1'b0;
        if (start) begin
          we_d    = we;
          size_d  = size;
          sext_d  = sign_ext;
          addr_d  = addr;
          wdata_d = wdata;
          if (is_misaligned(size, addr[1:0])) begin
            state_d    = StErr;
            misalign_d = 1'b1;
          end else begin
            state_d = StReq;
            cnt_d   = '0;
          end
        end
      end
      StReq: begin
        if (mem_ack) begin
          state_d = StDone;
          if (!we_q) rdata_d = lane_rdata;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d   = StErr;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StDone, StErr: state_d = StIdle;
      default:       state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      sext_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      size_q     <= size_d;
      sext_q     <= sext_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      misalign_q <= misalign_d;
      timeout_q  <= timeout_d;
      rdata_q    <= rdata_d;
    end
  end

  // Memory-side fields are zeroed outside REQ so the bus is quiet when idle.
  assign busy      = state_q != StIdle;
  assign done      = (state_q == StDone) || (state_q == StErr);
  assign misalign  = (state_q == StErr) && misalign_q;
  assign timeout   = (state_q == StErr) && timeout_q;
  assign mem_req   = state_q == StReq;
  assign mem_we    = mem_req && we_q;
  assign mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : '0;
  assign mem_be    = mem_req ? lane_be : 4'b0000;
  assign mem_wdata = mem_req ? lane_wdata : '0;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        start = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'd0;
  logic        sign_ext = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        busy, done, misalign, timeout, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  int total = 0;
  int bad = 0;
  logic [31:0] model_rdata = '0;

  // Observations of one access.
  int          dc, rc, ex;
  logic        o_mis, o_to, o_mwe, o_st;
  logic [3:0]  o_be;
  logic [31:0] o_addr, o_wd;

  always #5 CLK = ~CLK;

  load_store_unit #(.TIMEOUT(16), .CNT_W(8)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .start     (start),
    .we        (we),
    .size      (size),
    .sign_ext  (sign_ext),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .misalign  (misalign),
    .timeout   (timeout),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  // Reference model, written directly from the access rules.
  function automatic logic model_mis(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 3) || (sz == 1 && (a % 2) != 0) || (sz == 2 && (a % 4) != 0);
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
    int off = int'(a % 4);
    if (sz == 0) return 4'(1 << off);
    if (sz == 1) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wd(input logic [1:0] sz, input logic [31:0] w);
    if (sz == 0) return (w & 32'hFF) * 32'h0101_0101;
    if (sz == 1) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sx,
                                             input logic [31:0] a, input logic [31:0] mr);
    int off = int'(a % 4);
    logic [31:0] v = mr >> (8 * off);
    if (sz == 0) begin
      v = v & 32'hFF;
      if (sx && v >= 128) v = v + 32'hFFFF_FF00;
      return v;
    end
    if (sz == 1) begin
      v = v & 32'hFFFF;
      if (sx && v >= 32768) v = v + 32'hFFFF_0000;
      return v;
    end
    return mr;
  endfunction

  // Drives one request and acts as the memory. i_wait < 0 means never ack.
  // At cycle i_poke (if > 0) a stray start is pulsed while the unit is busy.
  task automatic run_access(input logic i_we, input logic [1:0] i_size, input logic i_sx,
                            input logic [31:0] i_addr, input logic [31:0] i_wd,
                            input logic [31:0] i_mrd, input int i_wait, input int i_poke);
    int cyc;
    @(negedge CLK);
    start = 1'b1; we = i_we; size = i_size; sign_ext = i_sx; addr = i_addr; wdata = i_wd;
    @(negedge CLK);
    cyc = 1; dc = -1; rc = 0; o_mis = 1'b0; o_to = 1'b0; o_st = 1'b1;
    o_be = '0; o_addr = '0; o_wd = '0; o_mwe = 1'b0;
    // Scramble request inputs so only latched values can be correct.
    start = 1'b0; we = ~i_we; size = 2'($urandom); sign_ext = ~i_sx;
    addr = $urandom; wdata = $urandom;
    while (cyc < 60 && dc < 0) begin
      if (done) begin
        dc = cyc; o_mis = misalign; o_to = timeout;
      end
      if (mem_req) begin
        if (rc == 0) begin
          o_be = mem_be; o_addr = mem_addr; o_wd = mem_wdata; o_mwe = mem_we;
        end else if (mem_be !== o_be || mem_addr !== o_addr || mem_wdata !== o_wd
                     || mem_we !== o_mwe) begin
          o_st = 1'b0;
        end
        rc++;
      end
      mem_ack   = mem_req && i_wait >= 0 && rc == i_wait + 1;
      mem_rdata = mem_ack ? i_mrd : $urandom;
      start     = (cyc == i_poke);
      if (dc < 0) begin
        @(negedge CLK);
        cyc++;
      end
    end
    mem_ack = 1'b0; start = 1'b0;
    ex = 0;
    repeat (5) begin
      @(negedge CLK);
      if (done || mem_req) ex++;
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; start = 1'b0; mem_ack = 1'b0;
    repeat (3) @(negedge CLK);
    total++;
    if ({busy, done, misalign, timeout, mem_req, mem_we, mem_be} !== 10'd0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=0",
                      {busy, done, misalign, timeout, mem_req, mem_we, mem_be});
    end
    total++;
    if ({mem_addr, mem_wdata, rdata} !== 96'd0) begin
      bad++; $display("FAIL reset_data got addr=%h wd=%h rd=%h want 0", mem_addr, mem_wdata,
                      rdata);
    end
    RESET = 1'b0;
    mem_ack = 1'b1;
    repeat (2) @(negedge CLK);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL idle_ack_ignored got busy=%b done=%b want 0 0", busy, done);
    end
    mem_ack = 1'b0;
    model_rdata = '0;
  endtask

  task automatic test_word_store();
    run_access(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEAD_BEEF, 32'h1234_5678, 2, 0);
    total++;
    if (dc !== 4 || rc !== 3) begin
      bad++; $display("FAIL st_word_timing got done=%0d req=%0d want 4 3", dc, rc);
    end
    total++;
    if (o_be !== 4'b1111 || o_wd !== 32'hDEAD_BEEF || o_addr !== 32'h100 || o_mwe !== 1'b1) begin
      bad++; $display("FAIL st_word_bus got be=%b wd=%h a=%h we=%b want 1111 deadbeef 100 1",
                      o_be, o_wd, o_addr, o_mwe);
    end
    total++;
    if (rdata !== model_rdata || o_mis !== 1'b0 || o_to !== 1'b0) begin
      bad++; $display("FAIL st_word_rdata got rd=%h mis=%b to=%b want %h 0 0", rdata, o_mis, o_to,
                      model_rdata);
    end
  endtask

  task automatic test_byte_load();
    run_access(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80FF_1234, 0, 0);
    model_rdata = 32'hFFFF_FF80;
    total++;
    if (dc !== 2 || o_be !== 4'b1000 || o_mwe !== 1'b0 || o_addr !== 32'h100) begin
      bad++; $display("FAIL ld_byte_bus got done=%0d be=%b we=%b a=%h want 2 1000 0 100",
                      dc, o_be, o_mwe, o_addr);
    end
    total++;
    if (rdata !== 32'hFFFF_FF80) begin
      bad++; $display("FAIL ld_byte_data got=%h want=ffffff80", rdata);
    end
  endtask

  task automatic test_half_load();
    run_access(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 32'h80FF_1234, 0, 0);
    total++;
    if (o_be !== 4'b1100 || rdata !== 32'h0000_80FF) begin
      bad++; $display("FAIL ld_half_u got be=%b rd=%h want 1100 000080ff", o_be, rdata);
    end
    run_access(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 32'h80FF_1234, 1, 0);
    model_rdata = 32'hFFFF_80FF;
    total++;
    if (dc !== 3 || rdata !== 32'hFFFF_80FF) begin
      bad++; $display("FAIL ld_half_s got done=%0d rd=%h want 3 ffff80ff", dc, rdata);
    end
  endtask

  task automatic test_misalign();
    logic [1:0] szs [2] = '{2'd2, 2'd3};
    logic [31:0] ads [2] = '{32'h102, 32'h0};
    for (int i = 0; i < 2; i++) begin
      run_access(1'b0, szs[i], 1'b0, ads[i], 32'h0, 32'hAAAA_5555, 0, 0);
      total++;
      if (dc !== 1 || o_mis !== 1'b1 || o_to !== 1'b0 || rc !== 0 || ex !== 0) begin
        bad++; $display("FAIL misalign_%0d got done=%0d mis=%b to=%b req=%0d ex=%0d want 1 1 0 0 0",
                        i, dc, o_mis, o_to, rc, ex);
      end
      total++;
      if (rdata !== model_rdata) begin
        bad++; $display("FAIL misalign_rdata_%0d got=%h want=%h", i, rdata, model_rdata);
      end
    end
  endtask

  task automatic test_timeout();
    run_access(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h0, -1, 0);
    total++;
    if (rc !== 16 || dc !== 17 || o_to !== 1'b1 || o_mis !== 1'b0) begin
      bad++; $display("FAIL timeout got req=%0d done=%0d to=%b mis=%b want 16 17 1 0",
                      rc, dc, o_to, o_mis);
    end
    total++;
    if (rdata !== model_rdata || ex !== 0) begin
      bad++; $display("FAIL timeout_rdata got rd=%h ex=%0d want %h 0", rdata, ex, model_rdata);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic        r_we  = 1'($urandom);
      logic [1:0]  r_sz  = 2'($urandom);
      logic        r_sx  = 1'($urandom);
      logic [31:0] r_a   = $urandom;
      logic [31:0] r_wd  = $urandom;
      logic [31:0] r_mr  = $urandom;
      int          r_w   = int'($urandom_range(0, 4));
      logic        mis   = model_mis(r_sz, r_a);
      run_access(r_we, r_sz, r_sx, r_a, r_wd, r_mr, r_w, 0);
      if (!mis && !r_we) model_rdata = model_load(r_sz, r_sx, r_a, r_mr);
      total++;
      if (dc !== (mis ? 1 : r_w + 2) || rc !== (mis ? 0 : r_w + 1) || o_mis !== mis
          || o_to !== 1'b0 || ex !== 0) begin
        bad++; $display("FAIL rnd_ctrl_%0d got done=%0d req=%0d mis=%b to=%b ex=%0d want %0d %0d %b",
                        i, dc, rc, o_mis, o_to, ex, mis ? 1 : r_w + 2, mis ? 0 : r_w + 1, mis);
      end
      if (!mis) begin
        total++;
        if (o_be !== model_be(r_sz, r_a) || o_wd !== model_wd(r_sz, r_wd) || o_mwe !== r_we
            || o_addr !== (r_a & 32'hFFFF_FFFC) || o_st !== 1'b1) begin
          bad++; $display("FAIL rnd_bus_%0d got be=%b wd=%h a=%h we=%b st=%b want %b %h %h %b 1",
                          i, o_be, o_wd, o_addr, o_mwe, o_st, model_be(r_sz, r_a),
                          model_wd(r_sz, r_wd), r_a & 32'hFFFF_FFFC, r_we);
        end
      end
      total++;
      if (rdata !== model_rdata) begin
        bad++; $display("FAIL rnd_rdata_%0d got=%h want=%h", i, rdata, model_rdata);
      end
    end
  endtask

  task automatic test_back_to_back_start();
    run_access(1'b1, 2'd2, 1'b0, 32'h80, 32'h0BAD_F00D, 32'h0, 3, 2);
    total++;
    if (dc !== 5 || rc !== 4 || ex !== 0 || o_st !== 1'b1) begin
      bad++; $display("FAIL busy_start got done=%0d req=%0d ex=%0d st=%b want 5 4 0 1",
                      dc, rc, ex, o_st);
    end
  endtask

  task automatic test_reset_mid();
    int extra = 0;
    run_access(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0000_0055, 0, 0);
    model_rdata = 32'h55;
    total++;
    if (rdata !== 32'h55) begin
      bad++; $display("FAIL pre_reset_load got=%h want=00000055", rdata);
    end
    @(negedge CLK);
    start = 1'b1; we = 1'b0; size = 2'd2; addr = 32'h200;
    @(negedge CLK);
    start = 1'b0;
    @(negedge CLK);
    total++;
    if (mem_req !== 1'b1) begin
      bad++; $display("FAIL mid_req got=%b want=1", mem_req);
    end
    RESET = 1'b1;
    @(negedge CLK);
    total++;
    if ({busy, done, mem_req} !== 3'b000 || rdata !== 32'h0) begin
      bad++; $display("FAIL mid_reset got busy/done/req=%b rd=%h want 000 0",
                      {busy, done, mem_req}, rdata);
    end
    RESET = 1'b0;
    model_rdata = '0;
    repeat (5) begin
      @(negedge CLK);
      if (done || mem_req) extra++;
    end
    total++;
    if (extra !== 0) begin
      bad++; $display("FAIL mid_reset_quiet got=%0d want=0", extra);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=expired want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_word_store();
    test_byte_load();
    test_half_load();
    test_misalign();
    test_timeout();
    test_random();
    test_back_to_back_start();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
